// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the 640x480@60 default porch/sync widths for both axes, the default
// counter width, the per-axis region enum and a helper that sums an axis total.
package vga_pkg;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;

    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;

    localparam int CNT_W_DEF    = 11;

    // Regions of one axis, in the order the counter walks through them.
    typedef enum logic [1:0] {
        REG_SYNC   = 2'd0,
        REG_BACK   = 2'd1,
        REG_ACTIVE = 2'd2,
        REG_FRONT  = 2'd3
    } region_e;

    function automatic int axis_total(input int sync_w, input int back_w,
                                      input int active_w, input int front_w);
        return sync_w + back_w + active_w + front_w;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One raster axis: wrapping counter plus sync/display/coordinate decode.
// Latency: decodes are combinational from the registered count (0 cycles).
// Backpressure: none; the count advances only on cycles where i_adv is high.
//
// Ports:
//   clk, reset_b   clock and synchronous active-low reset
//   i_adv          advance the count by one (wraps at TOTAL-1)
//   o_sync         sync level, POL while in the sync region
//   o_display      count lies in the active region
//   o_coord        offset into the active region, 0 outside it
//   o_last         count is at TOTAL-1 (not qualified by i_adv)
module vga_axis_timer
    import vga_pkg::*;
#(
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF,
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF,
    parameter bit POL    = 1'b0,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             i_adv,
    output logic             o_sync,
    output logic             o_display,
    output logic [CNT_W-1:0] o_coord,
    output logic             o_last
);

    localparam int TOTAL = axis_total(SYNC, BACK, ACTIVE, FRONT);

    // Reject widths that would make a region vanish or overflow the counter.
    if (SYNC < 1 || BACK < 1 || ACTIVE < 1 || FRONT < 1 || TOTAL > (2 ** CNT_W)) begin : g_bad_params
        $error("vga_axis_timer: illegal timing parameters");
    end

    localparam logic [CNT_W-1:0] BACK_LO = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO  = CNT_W'(SYNC + BACK);
    // FRONT >= 1 keeps ACT_HI <= TOTAL-1, so it always fits in CNT_W bits.
    localparam logic [CNT_W-1:0] ACT_HI  = CNT_W'(SYNC + BACK + ACTIVE);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_count;
    region_e          w_region;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_count <= '0;
        end else if (i_adv) begin
            r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_region = REG_FRONT;
        if (r_count < BACK_LO) begin
            w_region = REG_SYNC;
        end else if (r_count < ACT_LO) begin
            w_region = REG_BACK;
        end else if (r_count < ACT_HI) begin
            w_region = REG_ACTIVE;
        end
    end

    assign o_sync    = (w_region == REG_SYNC) ? POL : ~POL;
    assign o_display = (w_region == REG_ACTIVE);
    assign o_coord   = o_display ? (r_count - ACT_LO) : '0;
    assign o_last    = (r_count == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: nested H/V counters with sync, blanking, coordinates, ticks.
// Latency: all outputs decode the registered counters combinationally (0 cycles).
// Backpressure: none; pix_en gates every advance, counters hold while it is low.
//
// Ports:
//   inputclk, reset_b    clock and synchronous active-low reset
//   pix_en               pixel-clock enable
//   hsync, vsync         sync outputs at HSYNC_POL / VSYNC_POL while asserted
//   Hdisplay, Vdisplay   per-axis active region; display is their AND
//   pixel_x, pixel_y     coordinate inside the active area, 0 outside
//   linetic, frametic    one-cycle pulses on the last pixel of a line / frame
//   frame_count          16-bit wrapping frame counter, present only when
//                        VGA_TIMING_FRAMECNT_EN is defined
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             inputclk,
    input  logic             reset_b,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             Hdisplay,
    output logic             Vdisplay,
    output logic             display,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             linetic,
`ifdef VGA_TIMING_FRAMECNT_EN
    output logic [15:0]      frame_count,
`endif
    output logic             frametic
);

    logic w_h_last;
    logic w_v_last;

    vga_axis_timer #(
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .POL    (HSYNC_POL),
        .CNT_W  (CNT_W)
    ) u_h_axis (
        .clk       (inputclk),
        .reset_b   (reset_b),
        .i_adv     (pix_en),
        .o_sync    (hsync),
        .o_display (Hdisplay),
        .o_coord   (pixel_x),
        .o_last    (w_h_last)
    );

    // The vertical axis steps once per line, on the same edge hcount wraps.
    vga_axis_timer #(
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .POL    (VSYNC_POL),
        .CNT_W  (CNT_W)
    ) u_v_axis (
        .clk       (inputclk),
        .reset_b   (reset_b),
        .i_adv     (linetic),
        .o_sync    (vsync),
        .o_display (Vdisplay),
        .o_coord   (pixel_y),
        .o_last    (w_v_last)
    );

    assign display  = Hdisplay & Vdisplay;
    assign linetic  = pix_en & w_h_last;
    assign frametic = linetic & w_v_last;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge inputclk) begin
        if (!reset_b) begin
            r_frame_count <= '0;
        end else if (frametic) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule
